alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU of the datapath between NREQ requesters.
- Round-robin grant; operands and select are latched, and the ALU is driven for one cycle.
- The ALU result is captured and returned to the winning requester over a valid/ready response channel.
- Sits beside the ALU instance in the top level; the ALU itself is unchanged and connects through the alu_* ports.

Parameters:
- DWIDTH, 32, operand/result width
- NREQ, 2, number of requesters (2..8)
- SELW, 2, ALU select width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid_i  in  NREQ  request valid per requester
- req_ready_o  out  NREQ  request accepted (one-hot or zero)
- req_op1_i  in  NREQ*DWIDTH  packed operand 1, requester k at [k*DWIDTH +: DWIDTH]
- req_op2_i  in  NREQ*DWIDTH  packed operand 2, same packing
- req_sel_i  in  NREQ*SELW  packed ALU select
- resp_valid_o  out  NREQ  result valid, one-hot to the granted requester
- resp_ready_i  in  NREQ  requester accepts result
- resp_res_o  out  DWIDTH  result (shared bus, qualified by resp_valid_o)
- alu_op1_o  out  DWIDTH  to ALU op1_i
- alu_op2_o  out  DWIDTH  to ALU op2_i
- alu_sel_o  out  SELW  to ALU sel_i
- alu_res_i  in  DWIDTH  from ALU res_o
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, rr pointer=0, grant register=0.
  - Operand/select/result registers = 0.
  - All outputs 0.
- FSM IDLE:
  - Winner = first k with req_valid_i[k], searching from the rr pointer upward with wrap (NREQ-1 -> 0).
  - req_ready_o = onehot(winner) combinationally, only while in IDLE; zero if no valid.
  - On handshake: latch op1/op2/sel of the winner and its index; rr pointer <= (winner+1) mod NREQ; go to EXEC.
- FSM EXEC (exactly 1 cycle):
  - alu_op1_o/alu_op2_o/alu_sel_o = latched values.
  - At the clock edge, result register <= alu_res_i; go to RESP.
- FSM RESP:
  - resp_valid_o[granted]=1; resp_res_o = result register.
  - Held stable until resp_ready_i[granted]=1.
  - On that edge go to IDLE; resp_ready_i of non-granted bits is ignored.
- ALU drive outside EXEC: alu_* outputs = 0 in IDLE and RESP, so no spurious toggling.
- Latency and throughput:
  - Request handshake at edge N -> resp_valid_o high from cycle N+2 (after edge N+1).
  - Minimum 3 cycles per operation (IDLE, EXEC, RESP with ready already high).
- No back-to-back accept: req_ready_o is 0 in EXEC and RESP.
- req_valid_i may drop without handshake; a requester that is not granted keeps waiting and is not starved (worst-case wait NREQ-1 operations).
- Simultaneous requests: the rr pointer decides. After a grant to k, k has lowest priority.
- resp_ready_i high in the same cycle RESP is entered: completes that cycle.
- Reset mid-operation (EXEC or RESP): the operation is discarded, no response is issued, and state returns to IDLE.
- No arithmetic in this block; widths are pass-through.

Optional Feature:
- ALU_ARB_PERF_EN:
  - Defined: adds output perf_grants_o [NREQ*16], one 16-bit wrapping counter per requester, incremented on each request handshake, reset to 0.
  - Undefined: port absent, no counter logic.

Decomposition:
- Package alu_arb_pkg:
  - typedef enum logic [1:0] arb_state_e {IDLE, EXEC, RESP}
  - localparam PERF_CW=16
  - function onehot(idx)
- Sub-module rr_picker #(NREQ):
  - Inputs: valid vector, pointer.
  - Outputs: found flag, winner index.
  - Purely combinational; separately testable.

Test Plan (bench ALU model: res = op1 ^ op2 for sel=2'b01):
- Single request: req0 with op1=0x0000_00F0, op2=0x0000_000F, sel=01 -> alu_* driven only in EXEC; resp_valid_o=2'b01 two cycles after handshake, resp_res_o=0x0000_00FF.
- Both valid continuously, resp_ready_i=2'b11, pointer 0 after reset -> grant order 0,1,0,1; each operation takes 3 cycles.
- Response backpressure: resp_ready_i=0 for 5 cycles in RESP -> resp_valid_o and resp_res_o stable; req_ready_o=0 throughout; completes on the ready cycle.
- Async reset asserted mid-EXEC -> all outputs 0 immediately; no resp_valid_o after release; next grant goes to requester 0.
- req1 alone then req0+req1 -> after serving 1, pointer wraps to 0 and req0 is granted first.
- With ALU_ARB_PERF_EN: 3 grants to req1 -> perf_grants_o[31:16]=3, [15:0]=0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared FSM state type, perf counter width and one-hot helper for alu_arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;

    localparam int PERF_CW = 16;

    // Sized for the largest supported NREQ (8); callers truncate to NREQ bits.
    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search for the first valid requester at or above ptr, with wrap.
module rr_picker #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]                          valid,
    input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] ptr,
    output logic                                     found,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] idx
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] k;

    // Scan offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % NREQ);
            if (valid[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between NREQ requesters with a valid/ready response.
// Optional per-requester grant counters on perf_grants_o when ALU_ARB_PERF_EN is defined.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NREQ   = 2,
    parameter int SELW   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [NREQ*DWIDTH-1:0]   req_op1_i,
    input  logic [NREQ*DWIDTH-1:0]   req_op2_i,
    input  logic [NREQ*SELW-1:0]     req_sel_i,
    output logic [NREQ-1:0]          resp_valid_o,
    input  logic [NREQ-1:0]          resp_ready_i,
    output logic [DWIDTH-1:0]        resp_res_o,
    output logic [DWIDTH-1:0]        alu_op1_o,
    output logic [DWIDTH-1:0]        alu_op2_o,
    output logic [SELW-1:0]          alu_sel_o,
    input  logic [DWIDTH-1:0]        alu_res_i,
`ifdef ALU_ARB_PERF_EN
    output logic [NREQ*PERF_CW-1:0]  perf_grants_o,
`endif
    output logic                     busy_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        state, state_n;
    logic [IW-1:0]     ptr, grant, winner;
    logic              found, accept;
    logic [DWIDTH-1:0] op1_q, op2_q, res_q;
    logic [SELW-1:0]   sel_q;

    rr_picker #(.NREQ(NREQ)) u_pick (
        .valid (req_valid_i),
        .ptr   (ptr),
        .found (found),
        .idx   (winner)
    );

    assign accept = (state == IDLE) && found;

    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = found ? EXEC : IDLE;
        else if (state == EXEC)
            state_n = RESP;
        else
            state_n = resp_ready_i[grant] ? IDLE : RESP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            op1_q <= '0;
            op2_q <= '0;
            sel_q <= '0;
            res_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                grant <= winner;
                ptr   <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
                op1_q <= req_op1_i[winner*DWIDTH +: DWIDTH];
                op2_q <= req_op2_i[winner*DWIDTH +: DWIDTH];
                sel_q <= req_sel_i[winner*SELW +: SELW];
            end
            if (state == EXEC)
                res_q <= alu_res_i;
        end
    end

    // Ready is gated by rst so the comb path stays quiet while reset is held.
    assign req_ready_o  = (accept && !rst) ? NREQ'(onehot(3'(winner))) : '0;
    assign resp_valid_o = (state == RESP) ? NREQ'(onehot(3'(grant))) : '0;
    assign resp_res_o   = (state == RESP) ? res_q : '0;
    assign alu_op1_o    = (state == EXEC) ? op1_q : '0;
    assign alu_op2_o    = (state == EXEC) ? op2_q : '0;
    assign alu_sel_o    = (state == EXEC) ? sel_q : '0;
    assign busy_o       = state != IDLE;

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_grants_o <= '0;
        else if (accept)
            perf_grants_o[winner*PERF_CW +: PERF_CW] <= perf_grants_o[winner*PERF_CW +: PERF_CW] + 1'b1;
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter (NREQ=2) with a transaction-level round-robin model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [63:0] op1, op2;
    logic [3:0]  sel;
    logic [31:0] resp_res, alu_op1, alu_op2, alu_res;
    logic [1:0]  alu_sel;
    logic        busy;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int m_ptr    = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DWIDTH(32), .NREQ(2), .SELW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op1_i    (op1),
        .req_op2_i    (op2),
        .req_sel_i    (sel),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_res_o   (resp_res),
        .alu_op1_o    (alu_op1),
        .alu_op2_o    (alu_op2),
        .alu_sel_o    (alu_sel),
        .alu_res_i    (alu_res),
`ifdef ALU_ARB_PERF_EN
        .perf_grants_o(perf),
`endif
        .busy_o       (busy)
    );

    // External ALU stand-in: add, xor, and, or.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        return (s == 2'd0) ? a + b : (s == 2'd1) ? a ^ b : (s == 2'd2) ? a & b : a | b;
    endfunction

    assign alu_res = alu_f(alu_op1, alu_op2, alu_sel);

    // Reference arbitration: nearest valid requester at or after the model pointer.
    function automatic int pick(input logic [1:0] v);
        for (int off = 0; off < 2; off++)
            if (v[(m_ptr + off) % 2]) return (m_ptr + off) % 2;
        return -1;
    endfunction

    task automatic test_reset;
        rst = 1'b0;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        op1 = '0;
        op2 = '0;
        sel = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1;
        tot_cnt++; if ({req_ready, resp_valid, busy} !== 5'b0) $display("FAIL reset_ctl: got %b exp 0", {req_ready, resp_valid, busy}); else pass_cnt++;
        tot_cnt++; if ({alu_op1, alu_op2, alu_sel, resp_res} !== 98'b0) $display("FAIL reset_data: got %h exp 0", {alu_op1, alu_op2, alu_sel, resp_res}); else pass_cnt++;
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_single;
        @(negedge clk);
        req_valid = 2'b01;
        op1[31:0] = 32'h0000_00F0;
        op2[31:0] = 32'h0000_000F;
        sel[1:0] = 2'b01;
        #1;
        tot_cnt++; if (req_ready !== 2'b01) $display("FAIL single_ready: got %b exp 01", req_ready); else pass_cnt++;
        tot_cnt++; if ({alu_op1, alu_op2, alu_sel} !== 66'b0) $display("FAIL single_alu_idle: got %h exp 0", {alu_op1, alu_op2, alu_sel}); else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        tot_cnt++; if ({alu_op1, alu_op2, alu_sel} !== {32'hF0, 32'h0F, 2'b01}) $display("FAIL single_alu_exec: got %h exp %h", {alu_op1, alu_op2, alu_sel}, {32'hF0, 32'h0F, 2'b01}); else pass_cnt++;
        tot_cnt++; if ({req_ready, resp_valid, busy} !== 5'b00001) $display("FAIL single_exec_ctl: got %b exp 00001", {req_ready, resp_valid, busy}); else pass_cnt++;
        @(negedge clk);
        resp_ready = 2'b01;
        #1;
        tot_cnt++; if (resp_valid !== 2'b01) $display("FAIL single_resp_valid: got %b exp 01", resp_valid); else pass_cnt++;
        tot_cnt++; if (resp_res !== 32'h0000_00FF) $display("FAIL single_resp_res: got %h exp 000000ff", resp_res); else pass_cnt++;
        tot_cnt++; if ({alu_op1, alu_op2, alu_sel} !== 66'b0) $display("FAIL single_alu_resp: got %h exp 0", {alu_op1, alu_op2, alu_sel}); else pass_cnt++;
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        tot_cnt++; if ({resp_valid, busy} !== 3'b0) $display("FAIL single_done: got %b exp 000", {resp_valid, busy}); else pass_cnt++;
        m_ptr = 1;
    endtask

    task automatic test_backpressure;
        int k;
        logic [31:0] exp_res;
        logic [1:0] g;
        @(negedge clk);
        req_valid = 2'b11;
        op1 = {$urandom, $urandom};
        op2 = {$urandom, $urandom};
        sel = 4'($urandom);
        k = pick(req_valid);
        g = 2'b01 << k;
        exp_res = alu_f(op1[k*32 +: 32], op2[k*32 +: 32], sel[k*2 +: 2]);
        #1;
        tot_cnt++; if (req_ready !== g) $display("FAIL bp_grant: got %b exp %b", req_ready, g); else pass_cnt++;
        m_ptr = (k + 1) % 2;
        @(negedge clk);
        #1;
        tot_cnt++; if (req_ready !== 2'b00) $display("FAIL bp_exec_ready: got %b exp 00", req_ready); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            resp_ready = ~g;
            #1;
            tot_cnt++; if ({resp_valid, resp_res, req_ready} !== {g, exp_res, 2'b00}) $display("FAIL bp_hold%0d: got %h exp %h", i, {resp_valid, resp_res, req_ready}, {g, exp_res, 2'b00}); else pass_cnt++;
        end
        @(negedge clk);
        resp_ready = g;
        #1;
        tot_cnt++; if ({resp_valid, resp_res} !== {g, exp_res}) $display("FAIL bp_release: got %h exp %h", {resp_valid, resp_res}, {g, exp_res}); else pass_cnt++;
        @(negedge clk);
        resp_ready = 2'b00;
        req_valid = 2'b00;
        #1;
        tot_cnt++; if ({resp_valid, busy} !== 3'b0) $display("FAIL bp_done: got %b exp 000", {resp_valid, busy}); else pass_cnt++;
    endtask

    task automatic test_reset_mid_exec;
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        tot_cnt++; if (busy !== 1'b1) $display("FAIL rst_mid_busy: got %b exp 1", busy); else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        tot_cnt++; if ({req_ready, resp_valid, busy, alu_op1, alu_op2, alu_sel, resp_res} !== 103'b0) $display("FAIL rst_mid_outputs: got %h exp 0", {req_ready, resp_valid, busy, alu_op1, alu_op2, alu_sel, resp_res}); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            tot_cnt++; if ({resp_valid, busy} !== 3'b0) $display("FAIL rst_mid_noresp%0d: got %b exp 000", i, {resp_valid, busy}); else pass_cnt++;
        end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        tot_cnt++; if (req_ready !== 2'b01) $display("FAIL rst_mid_next_grant: got %b exp 01", req_ready); else pass_cnt++;
        req_valid = 2'b00;
    endtask

    task automatic test_back_to_back;
        int k;
        logic [1:0] g;
        @(negedge clk);
        req_valid = 2'b11;
        resp_ready = 2'b11;
        op1 = {$urandom, $urandom};
        op2 = {$urandom, $urandom};
        sel = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            k = pick(req_valid);
            g = 2'b01 << (i % 2);
            tot_cnt++; if (req_ready !== g) $display("FAIL rr_grant%0d: got %b exp %b", i, req_ready, g); else pass_cnt++;
            m_ptr = (k + 1) % 2;
            @(negedge clk);
            #1;
            tot_cnt++; if ({req_ready, alu_op1} !== {2'b00, op1[k*32 +: 32]}) $display("FAIL rr_exec%0d: got %h exp %h", i, {req_ready, alu_op1}, {2'b00, op1[k*32 +: 32]}); else pass_cnt++;
            @(negedge clk);
            if (i == 3) req_valid = 2'b00;
            #1;
            tot_cnt++; if ({resp_valid, resp_res} !== {g, alu_f(op1[k*32 +: 32], op2[k*32 +: 32], sel[k*2 +: 2])}) $display("FAIL rr_resp%0d: got %h exp %h", i, {resp_valid, resp_res}, {g, alu_f(op1[k*32 +: 32], op2[k*32 +: 32], sel[k*2 +: 2])}); else pass_cnt++;
        end
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL rr_done: got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_wrap;
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        tot_cnt++; if (req_ready !== 2'b10) $display("FAIL wrap_first: got %b exp 10", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        resp_ready = 2'b11;
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        tot_cnt++; if (req_ready !== 2'b01) $display("FAIL wrap_second: got %b exp 01", req_ready); else pass_cnt++;
        req_valid = 2'b00;
        m_ptr = 0;
    endtask

    task automatic test_random;
        int k, d;
        logic [31:0] e1, e2;
        logic [1:0] es, g;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            req_valid = 2'($urandom_range(1, 3));
            op1 = {$urandom, $urandom};
            op2 = {$urandom, $urandom};
            sel = 4'($urandom);
            resp_ready = 2'($urandom);
            k = pick(req_valid);
            g = 2'b01 << k;
            e1 = op1[k*32 +: 32];
            e2 = op2[k*32 +: 32];
            es = sel[k*2 +: 2];
            d = $urandom_range(0, 3);
            #1;
            tot_cnt++; if (req_ready !== g) $display("FAIL rnd_grant%0d: got %b exp %b", n, req_ready, g); else pass_cnt++;
            m_ptr = (k + 1) % 2;
            @(negedge clk);
            req_valid = 2'($urandom);
            op1 = {$urandom, $urandom};
            op2 = {$urandom, $urandom};
            sel = 4'($urandom);
            #1;
            tot_cnt++; if ({alu_op1, alu_op2, alu_sel} !== {e1, e2, es}) $display("FAIL rnd_exec%0d: got %h exp %h", n, {alu_op1, alu_op2, alu_sel}, {e1, e2, es}); else pass_cnt++;
            for (int j = 0; j <= d; j++) begin
                @(negedge clk);
                resp_ready = (j == d) ? (2'($urandom) | g) : (2'($urandom) & ~g);
                #1;
                tot_cnt++; if ({resp_valid, resp_res, req_ready} !== {g, alu_f(e1, e2, es), 2'b00}) $display("FAIL rnd_resp%0d_%0d: got %h exp %h", n, j, {resp_valid, resp_res, req_ready}, {g, alu_f(e1, e2, es), 2'b00}); else pass_cnt++;
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        resp_ready = 2'b00;
        #1;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL rnd_done: got %b exp 0", busy); else pass_cnt++;
    endtask

`ifdef ALU_ARB_PERF_EN
    task automatic test_perf;
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 2'b10;
            @(negedge clk);
            req_valid = 2'b00;
            @(negedge clk);
            resp_ready = 2'b10;
            @(negedge clk);
            resp_ready = 2'b00;
        end
        #1;
        tot_cnt++; if (perf !== {16'd3, 16'd0}) $display("FAIL perf_grants: got %h exp %h", perf, {16'd3, 16'd0}); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_reset_mid_exec;
        test_back_to_back;
        test_wrap;
        test_random;
`ifdef ALU_ARB_PERF_EN
        test_perf;
`endif
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
